prog_feeder: RTL and testbench

Instruction sequencer that drives the 9-bit processor's DIN/Run/Done handshake from an internal program store. Software or a test harness loads up to DEPTH 9-bit words while idle. It then pulses Start, and the feeder issues each instruction in order. For `mvi` (opcode 001) it follows the instruction with its data word, and it waits for Done before issuing the next instruction. It sits beside the processor and takes the place of the manual DIN switches and Run key.

---
 rtl/proc_pkg.sv | 23 ++
 rtl/prog_mem.sv | 23 ++
 rtl/prog_feeder.sv | 128 ++++++++++++
 tb/tb_prog_feeder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor and its program feeder:
// word width, opcode constants and feeder state encoding.
package proc_pkg;
  localparam int WORD_W = 9;

  localparam logic [2:0] MV  = 3'b000;
  localparam logic [2:0] MVI = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    WAIT  = 2'd3
  } feed_state_e;

  function automatic logic [2:0] opcode_of(input word_t w);
    return w[WORD_W-1:WORD_W-3];
  endfunction
endpackage

// File: rtl/prog_mem.sv
// DEPTH x 9 program store: synchronous write, asynchronous read.
// Not reset, so a loaded program survives a processor reset.
module prog_mem
  import proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);
  word_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/prog_feeder.sv
// Replays a stored program into the processor's DIN/Run/Done handshake.
// Optional PROG_FEEDER_WATCHDOG_EN aborts a WAIT with Err after 7 cycles without Done.
module prog_feeder
  import proc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              WrEn,
  input  logic [AW-1:0]     WrAddr,
  input  logic [WORD_W-1:0] WrData,
  input  logic              Start,
  input  logic [AW:0]       Count,
  input  logic              Done,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  output logic [AW-1:0]     PC,
  output logic              Busy,
  output logic              Err
);
  localparam logic [AW:0] PC_ONE = {{AW{1'b0}}, 1'b1};

  feed_state_e state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] end_q, end_d;
  logic        err_q, err_d;
  word_t       rd_word;
  logic        idle;
  logic        wd_expired;

  assign idle = (state_q == IDLE);

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (Clock),
    .we_i    (WrEn && idle),
    .waddr_i (WrAddr),
    .wdata_i (WrData),
    .raddr_i (pc_q[AW-1:0]),
    .rdata_o (rd_word)
  );

`ifdef PROG_FEEDER_WATCHDOG_EN
  logic [2:0] wd_q, wd_d;

  assign wd_d       = (state_q == WAIT) ? wd_q + 3'd1 : 3'd0;
  assign wd_expired = (state_q == WAIT) && !Done && (wd_q == 3'd6);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) wd_q <= 3'd0;
    else         wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          end_d   = Count;
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = (Count == '0) ? IDLE : ISSUE;
        end
      end
      ISSUE: begin
        pc_d    = pc_q + PC_ONE;
        state_d = (opcode_of(rd_word) == MVI) ? DATA : WAIT;
      end
      DATA: begin
        pc_d = pc_q + PC_ONE;
        // A data word at or past End, or a missing Done, aborts the program.
        if (!Done || pc_q >= end_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = (pc_d >= end_q) ? IDLE : ISSUE;
        end
      end
      WAIT: begin
        if (Done) begin
          state_d = (pc_q >= end_q) ? IDLE : ISSUE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    DIN = '0;
    Run = 1'b0;
    case (state_q)
      ISSUE: begin
        DIN = rd_word;
        Run = 1'b1;
      end
      DATA:    DIN = rd_word;
      default: ;
    endcase
  end

  assign PC   = pc_q[AW-1:0];
  assign Busy = !idle;
  assign Err  = err_q;
endmodule

// File: tb/tb_prog_feeder.sv
module tb_prog_feeder;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          Clock  = 1'b0;
  logic          Resetn = 1'b0;
  logic          WrEn   = 1'b0;
  logic [AW-1:0] WrAddr = '0;
  logic [8:0]    WrData = '0;
  logic          Start  = 1'b0;
  logic [AW:0]   Count  = '0;
  logic          Done   = 1'b0;
  logic [8:0]    DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Err;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] prog [DEPTH];
  logic [8:0] R [8];

  logic [8:0] obs_issue [$];
  logic [8:0] obs_data  [$];
  int         obs_runcyc [$];
  int         obs_cycles;
  bit         obs_timeout;

  logic [8:0] exp_issue [$];
  logic [8:0] exp_data  [$];
  int         exp_pc;
  bit         exp_err;
  int         exp_cycles;

  prog_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Start(Start), .Count(Count), .Done(Done), .DIN(DIN), .Run(Run), .PC(PC),
    .Busy(Busy), .Err(Err)
  );

  always #5 Clock = ~Clock;

  function automatic logic [8:0] enc(input int op, input int x, input int y);
    logic [8:0] w;
    w = {op[2:0], x[2:0], y[2:0]};
    return w;
  endfunction

  // Processor behaviour: what a completed instruction does to the register file.
  function automatic void exec(input logic [8:0] w, input logic [8:0] d);
    case (w[8:6])
      3'b000: R[w[5:3]] = R[w[2:0]];
      3'b001: R[w[5:3]] = d;
      3'b010: R[w[5:3]] = R[w[5:3]] + R[w[2:0]];
      3'b011: R[w[5:3]] = R[w[5:3]] - R[w[2:0]];
      default: ;
    endcase
  endfunction

  // Expected feeder behaviour straight from the program text.
  function automatic void model(input int cnt);
    int pc;
    logic [8:0] w;
    exp_issue.delete();
    exp_data.delete();
    pc = 0; exp_err = 0; exp_cycles = 0;
    while (pc < cnt) begin
      w = prog[pc % DEPTH];
      exp_issue.push_back(w);
      pc++;
      if (w[8:6] == 3'b001) begin
        exp_data.push_back(prog[pc % DEPTH]);
        if (pc >= cnt) exp_err = 1;
        pc++;
        exp_cycles += 2;
      end else begin
        exp_cycles += (w[8:6] == 3'b000) ? 2 : 4;
      end
    end
    exp_pc = pc;
  endfunction

  task automatic write_word(input int a, input logic [8:0] w);
    WrEn = 1'b1; WrAddr = a[AW-1:0]; WrData = w;
    prog[a] = w;
    @(posedge Clock); #1;
    WrEn = 1'b0;
  endtask

  // Starts the program and plays the processor side until the feeder goes idle.
  task automatic run_prog(input int cnt, input bit disturb);
    int cyc, left;
    bit pend;
    logic [8:0] ir;
    obs_issue.delete(); obs_data.delete(); obs_runcyc.delete();
    cyc = 0; left = 0; pend = 0; ir = '0;
    Count = cnt[AW:0]; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    while (Busy && cyc < 400) begin
      Done = 1'b0;
      if (Run) begin
        obs_issue.push_back(DIN);
        obs_runcyc.push_back(cyc);
        ir = DIN;
        if (ir[8:6] == 3'b001) pend = 1;
        else left = (ir[8:6] == 3'b000) ? 1 : 3;
      end else if (pend) begin
        obs_data.push_back(DIN);
        Done = 1'b1;
        pend = 0;
        exec(ir, DIN);
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          Done = 1'b1;
          exec(ir, '0);
        end
      end
      if (disturb && cyc == 2) begin
        Start = 1'b1; WrEn = 1'b1; WrAddr = '0; WrData = ~prog[0]; Count = '0;
      end
      @(posedge Clock); #1;
      Start = 1'b0; WrEn = 1'b0; Done = 1'b0; Count = cnt[AW:0];
      cyc++;
    end
    obs_cycles  = cyc;
    obs_timeout = Busy;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (DIN !== 9'd0) begin n_err++; $display("FAIL reset_din got %h want 000", DIN); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL reset_run got %b want 0", Run); end
    n_vec++; if (PC !== '0) begin n_err++; $display("FAIL reset_pc got %0d want 0", PC); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", Err); end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(i, 9'd0);
    for (int i = 0; i < 8; i++) R[i] = '0;
  endtask

  task automatic test_mvi_mv;
    write_word(0, enc(1, 0, 0));
    write_word(1, 9'd5);
    write_word(2, enc(0, 1, 0));
    run_prog(3, 0);
    n_vec++; if (obs_timeout) begin n_err++; $display("FAIL mvi_mv_timeout busy stuck"); end
    n_vec++; if (R[0] !== 9'd5) begin n_err++; $display("FAIL mvi_mv_r0 got %0d want 5", R[0]); end
    n_vec++; if (R[1] !== 9'd5) begin n_err++; $display("FAIL mvi_mv_r1 got %0d want 5", R[1]); end
    n_vec++; if (obs_issue.size() != 2) begin n_err++; $display("FAIL mvi_mv_runs got %0d want 2", obs_issue.size()); end
    n_vec++; if (obs_cycles != 4) begin n_err++; $display("FAIL mvi_mv_busy_len got %0d want 4", obs_cycles); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL mvi_mv_err got %b want 0", Err); end
  endtask

  task automatic test_add_sub;
    int sp;
    write_word(0, enc(2, 0, 1));
    write_word(1, enc(3, 1, 0));
    R[0] = 9'd7; R[1] = 9'd2;
    run_prog(2, 0);
    sp = (obs_runcyc.size() >= 2) ? obs_runcyc[1] - obs_runcyc[0] : -1;
    n_vec++; if (sp != 4) begin n_err++; $display("FAIL add_sub_spacing got %0d want 4", sp); end
    n_vec++; if (PC !== 5'd2) begin n_err++; $display("FAIL add_sub_pc got %0d want 2", PC); end
    n_vec++; if (R[0] !== 9'd9) begin n_err++; $display("FAIL add_sub_r0 got %0d want 9", R[0]); end
    n_vec++; if (R[1] !== 9'd505) begin n_err++; $display("FAIL add_sub_r1 got %0d want 505", R[1]); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL add_sub_busy got %b want 0", Busy); end
  endtask

  task automatic test_mvi_last;
    logic [8:0] d;
    write_word(0, enc(1, 2, 0));
    write_word(1, 9'h0AB);
    run_prog(1, 0);
    d = (obs_data.size() > 0) ? obs_data[0] : 9'h1FF;
    n_vec++; if (d !== 9'h0AB) begin n_err++; $display("FAIL mvi_last_din got %h want 0ab", d); end
    n_vec++; if (Err !== 1'b1) begin n_err++; $display("FAIL mvi_last_err got %b want 1", Err); end
    n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL mvi_last_busy got %b want 0", Busy); end
    n_vec++; if (PC !== 5'd2) begin n_err++; $display("FAIL mvi_last_pc got %0d want 2", PC); end
  endtask

  task automatic test_count_zero;
    int seen_busy, seen_run;
    seen_busy = 0; seen_run = 0;
    Count = '0; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (Busy) seen_busy++;
      if (Run) seen_run++;
      @(posedge Clock); #1;
    end
    n_vec++; if (seen_busy != 0) begin n_err++; $display("FAIL count0_busy got %0d cycles want 0", seen_busy); end
    n_vec++; if (seen_run != 0) begin n_err++; $display("FAIL count0_run got %0d cycles want 0", seen_run); end
    n_vec++; if (Err !== 1'b0) begin n_err++; $display("FAIL count0_err got %b want 0", Err); end
  endtask

  task automatic test_ignore_busy;
    write_word(0, enc(2, 2, 3));
    write_word(1, enc(0, 4, 2));
    write_word(2, enc(2, 5, 5));
    write_word(3, enc(0, 6, 0));
    model(4);
    for (int pass = 0; pass < 2; pass++) begin
      run_prog(4, pass == 0);
      n_vec++;
      if (obs_issue.size() != exp_issue.size()) begin
        n_err++; $display("FAIL ignore_len pass %0d got %0d want %0d", pass, obs_issue.size(), exp_issue.size());
      end else begin
        for (int i = 0; i < exp_issue.size(); i++) begin
          n_vec++;
          if (obs_issue[i] !== exp_issue[i]) begin
            n_err++; $display("FAIL ignore_word pass %0d idx %0d got %h want %h", pass, i, obs_issue[i], exp_issue[i]);
          end
        end
      end
      n_vec++; if (PC !== 5'd4) begin n_err++; $display("FAIL ignore_pc pass %0d got %0d want 4", pass, PC); end
    end
  endtask

  task automatic test_reset_mid;
    write_word(0, enc(0, 1, 2));
    Count = 6'd1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    n_vec++; if (Busy !== 1'b1 || PC !== 5'd1) begin n_err++; $display("FAIL rstmid_pre busy %b pc %0d want 1 1", Busy, PC); end
    Resetn = 1'b0;
    #1;
    n_vec++; if ({DIN, Run, PC, Busy, Err} !== '0) begin
      n_err++; $display("FAIL rstmid_outs din %h run %b pc %0d busy %b err %b want all 0", DIN, Run, PC, Busy, Err);
    end
    @(posedge Clock); #1;
    Resetn = 1'b1;
    run_prog(1, 0);
    n_vec++; if (obs_issue.size() != 1 || obs_issue[0] !== enc(0, 1, 2)) begin
      n_err++; $display("FAIL rstmid_store got %0d words first %h want %h", obs_issue.size(), (obs_issue.size() > 0) ? obs_issue[0] : 9'h0, enc(0, 1, 2));
    end
  endtask

  task automatic test_watchdog;
    int k;
    write_word(0, enc(0, 0, 1));
    Count = 6'd1; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    k = 0;
`ifdef PROG_FEEDER_WATCHDOG_EN
    while (Busy && k < 20) begin
      @(posedge Clock); #1;
      k++;
    end
    n_vec++; if (k != 7) begin n_err++; $display("FAIL watchdog_delay got %0d want 7", k); end
    n_vec++; if (Err !== 1'b1) begin n_err++; $display("FAIL watchdog_err got %b want 1", Err); end
`else
    repeat (20) begin
      @(posedge Clock); #1;
      if (Busy) k++;
    end
    n_vec++; if (k != 20) begin n_err++; $display("FAIL hold_busy got %0d want 20", k); end
    Done = 1'b1;
    @(posedge Clock); #1;
    Done = 1'b0;
    n_vec++; if (Busy !== 1'b0 || Err !== 1'b0) begin
      n_err++; $display("FAIL hold_release busy %b err %b want 0 0", Busy, Err);
    end
`endif
  endtask

  task automatic test_random;
    int cnt, op;
    for (int it = 0; it < 8; it++) begin
      cnt = $urandom_range(1, 12);
      for (int a = 0; a <= cnt; a++) begin
        op = $urandom_range(0, 3);
        if (a > 0 && prog[a-1][8:6] == 3'b001 && $urandom_range(0, 1) == 1)
          write_word(a, 9'($urandom_range(0, 511)));
        else
          write_word(a, enc(op, $urandom_range(0, 7), $urandom_range(0, 7)));
      end
      model(cnt);
      run_prog(cnt, 0);
      n_vec++; if (obs_timeout) begin n_err++; $display("FAIL rand_timeout it %0d", it); end
      n_vec++; if (obs_runcyc.size() == 0 || obs_runcyc[0] != 0) begin n_err++; $display("FAIL rand_first_run it %0d not in first cycle", it); end
      n_vec++;
      if (obs_issue.size() != exp_issue.size() || obs_data.size() != exp_data.size()) begin
        n_err++; $display("FAIL rand_len it %0d issue %0d/%0d data %0d/%0d", it, obs_issue.size(), exp_issue.size(), obs_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_issue.size(); i++) begin
          n_vec++; if (obs_issue[i] !== exp_issue[i]) begin n_err++; $display("FAIL rand_issue it %0d idx %0d got %h want %h", it, i, obs_issue[i], exp_issue[i]); end
        end
        for (int i = 0; i < exp_data.size(); i++) begin
          n_vec++; if (obs_data[i] !== exp_data[i]) begin n_err++; $display("FAIL rand_data it %0d idx %0d got %h want %h", it, i, obs_data[i], exp_data[i]); end
        end
      end
      n_vec++; if (PC !== exp_pc[AW-1:0]) begin n_err++; $display("FAIL rand_pc it %0d got %0d want %0d", it, PC, exp_pc[AW-1:0]); end
      n_vec++; if (Err !== exp_err) begin n_err++; $display("FAIL rand_err it %0d got %b want %b", it, Err, exp_err); end
      n_vec++; if (obs_cycles != exp_cycles) begin n_err++; $display("FAIL rand_cycles it %0d got %0d want %0d", it, obs_cycles, exp_cycles); end
    end
  endtask

  initial begin
    test_reset;
    test_mvi_mv;
    test_add_sub;
    test_mvi_last;
    test_count_zero;
    test_ignore_busy;
    test_reset_mid;
    test_watchdog;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
